// File: rtl/vga_line_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_capture
// Purpose  : Host-side scan-line grabber. Watches the emulated VGA stream
//            (pixel tick, hsync, vsync, 1-bit pixel), and on an arm request
//            captures one selected active line into a byte buffer, 8 pixels
//            per byte with pixel 0 in bit 7 of byte 0, for host readback.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_emu   in   1       single clock, rising edge
//   reset_n   in   1       asynchronous active-low reset
//   p_tick_ex in   1       pixel tick from the video source (asynchronous)
//   hsync_ex  in   1       horizontal sync from the video source
//   vsync_ex  in   1       vertical sync from the video source
//   pixel_ex  in   1       pixel bit, valid while p_tick_ex is high
//   arm       in   1       one-cycle pulse: start capture of line_sel
//   line_sel  in   9       active line index, sampled on arm
//   rd_addr   in   ADDR_W  buffer byte address
//   rd_data   out  8       buffer[rd_addr], registered (1-cycle latency)
//   busy      out  1       capture in progress
//   done      out  1       line captured, held until next arm or reset
//   err       out  1       illegal line_sel or vsync mid-capture, held
// ============================================================================
module vga_line_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter bit SYNC_NEG = 1'b1,
  parameter int ADDR_W   = 7
) (
  input  logic              clk_emu,
  input  logic              reset_n,
  input  logic              p_tick_ex,
  input  logic              hsync_ex,
  input  logic              vsync_ex,
  input  logic              pixel_ex,
  input  logic              arm,
  input  logic [8:0]        line_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int   N_BYTES   = H_ACTIVE / 8;
  localparam int   MEM_DEPTH = 1 << ADDR_W;
  // Level of hsync/vsync when NOT in the sync pulse.
  localparam logic SYNC_IDLE = SYNC_NEG;

  localparam logic [9:0] H_BP_C     = 10'(H_BP);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] V_BP_C     = 10'(V_BP);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_VS  = 3'd1,
    S_COUNT_LN = 3'd2,
    S_SKIP_BP  = 3'd3,
    S_CAPTURE  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers. Bit 0 is the metastability flop, bit 1 the
  // synchronised value, bit 2 a one-cycle-delayed copy used for edge detect.
  // Sync chains reset to the idle sync level so reset release never looks
  // like a sync deassertion.
  // --------------------------------------------------------------------------
  logic [2:0] ptick_q, ptick_d;
  logic [2:0] hs_q,    hs_d;
  logic [2:0] vs_q,    vs_d;
  logic [1:0] pix_q,   pix_d;

  always_comb begin
    ptick_d = {ptick_q[1:0], p_tick_ex};
    hs_d    = {hs_q[1:0],    hsync_ex};
    vs_d    = {vs_q[1:0],    vsync_ex};
    pix_d   = {pix_q[0],     pixel_ex};
  end

  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) begin
      ptick_q <= 3'b000;
      hs_q    <= {3{SYNC_IDLE}};
      vs_q    <= {3{SYNC_IDLE}};
      pix_q   <= 2'b00;
    end else begin
      ptick_q <= ptick_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pix_q   <= pix_d;
    end
  end

  logic pixel_s;
  logic ev_pt;   // pixel tick rising edge
  logic ev_he;   // hsync leaves its active level
  logic ev_ve;   // vsync leaves its active level
  logic ev_va;   // vsync currently active

  always_comb begin
    pixel_s = pix_q[1];
    ev_pt   = ptick_q[1] & ~ptick_q[2];
    ev_he   = (hs_q[1] == SYNC_IDLE) & (hs_q[2] != SYNC_IDLE);
    ev_ve   = (vs_q[1] == SYNC_IDLE) & (vs_q[2] != SYNC_IDLE);
    ev_va   = (vs_q[1] != SYNC_IDLE);
  end

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [8:0]  line_sel_q, line_sel_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  px_cnt_q,   px_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [9:0]        line_inc;
  logic [9:0]        px_inc;
  logic [9:0]        line_target;
  logic              sel_legal;
  logic              in_frame;

  // Saturating increment: counters stick at all-ones rather than wrap.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    line_sel_d = line_sel_q;
    line_cnt_d = line_cnt_q;
    px_cnt_d   = px_cnt_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    line_inc    = sat_inc(line_cnt_q);
    px_inc      = sat_inc(px_cnt_q);
    line_target = V_BP_C + {1'b0, line_sel_q};
    sel_legal   = ({1'b0, line_sel} < V_ACTIVE_C);
    in_frame    = (state_q == S_COUNT_LN) || (state_q == S_SKIP_BP) ||
                  (state_q == S_CAPTURE);

    // The completed byte is the shift register plus the incoming pixel,
    // stored at the byte index of the pixel being shifted in.
    wr_en   = 1'b0;
    wr_addr = ADDR_W'(px_cnt_q >> 3);
    wr_data = {shift_q[6:0], pixel_s};

    if (arm) begin
      // Arm has priority over everything, including an abort this cycle.
      done_d = 1'b0;
      if (sel_legal) begin
        state_d    = S_WAIT_VS;
        line_sel_d = line_sel;
        line_cnt_d = 10'd0;
        px_cnt_d   = 10'd0;
        busy_d     = 1'b1;
        err_d      = 1'b0;
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end
    end else if (ev_va && in_frame) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT_VS: begin
          // Only a vsync deassertion starts line counting, so a capture
          // armed mid-frame lands in the next frame.
          if (ev_ve) state_d = S_COUNT_LN;
        end
        S_COUNT_LN: begin
          if (ev_he) begin
            line_cnt_d = line_inc;
            if (line_inc == line_target) begin
              state_d  = S_SKIP_BP;
              px_cnt_d = 10'd0;
            end
          end
        end
        S_SKIP_BP: begin
          if (ev_pt) begin
            px_cnt_d = px_inc;
            if (px_inc == H_BP_C) begin
              state_d  = S_CAPTURE;
              px_cnt_d = 10'd0;
            end
          end
        end
        S_CAPTURE: begin
          if (ev_pt) begin
            shift_d  = {shift_q[6:0], pixel_s};
            px_cnt_d = px_inc;
            if (px_inc[2:0] == 3'd0) wr_en = 1'b1;
            if (px_inc == H_ACTIVE_C) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      line_sel_q <= 9'd0;
      line_cnt_q <= 10'd0;
      px_cnt_q   <= 10'd0;
      shift_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_sel_q <= line_sel_d;
      line_cnt_q <= line_cnt_d;
      px_cnt_q   <= px_cnt_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer: contents are not reset; only the read register is.
  // --------------------------------------------------------------------------
  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk_emu) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = (int'(rd_addr) < N_BYTES) ? mem_q[rd_addr] : 8'h00;
  end

  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) rd_data_q <= 8'h00;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_line_capture
// Purpose  : Self-checking bench for vga_line_capture using a reduced video
//            timing (32x12 active) so full frames stay short. A free-running
//            frame generator drives the video inputs; expected buffer bytes
//            come from the generator's pixel function for the selected line.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_line_capture;

  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HS  = 4;
  localparam int HBP = 4;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int AW  = 3;
  localparam int NB  = HA / 8;
  localparam int CPP = 4;                    // clocks per pixel
  localparam int FRAME_CYC   = HT * VT * CPP;
  localparam int DONE_BUDGET = 3 * FRAME_CYC;

  logic          clk_emu   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          p_tick_ex = 1'b0;
  logic          hsync_ex  = 1'b1;
  logic          vsync_ex  = 1'b1;
  logic          pixel_ex  = 1'b0;
  logic          arm       = 1'b0;
  logic [8:0]    line_sel  = 9'd0;
  logic [AW-1:0] rd_addr   = '0;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          err;

  vga_line_capture #(
    .H_ACTIVE (HA),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_BP     (VBP),
    .SYNC_NEG (1'b1),
    .ADDR_W   (AW)
  ) dut (
    .clk_emu   (clk_emu),
    .reset_n   (reset_n),
    .p_tick_ex (p_tick_ex),
    .hsync_ex  (hsync_ex),
    .vsync_ex  (vsync_ex),
    .pixel_ex  (pixel_ex),
    .arm       (arm),
    .line_sel  (line_sel),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_emu = ~clk_emu;

  // ---------------- video source model ----------------
  int gen_v     = 0;
  int gen_h     = 0;
  int gen_frame = 0;
  int pat_mode  = 0;   // 0: px 0..7 lit, 1: even px lit, 2: random table
  bit force_vs  = 1'b0;
  bit rand_px [VA][HA];

  function automatic logic pix_of(input int v, input int h);
    if (v >= VA || h >= HA) return 1'b0;
    case (pat_mode)
      0:       return logic'(h < 8);
      1:       return logic'(h % 2 == 0);
      default: return logic'(rand_px[v][h]);
    endcase
  endfunction

  // Expected byte a of captured line: pixel 8a+i lands in bit 7-i.
  function automatic logic [7:0] exp_byte(input int line, input int a);
    logic [7:0] b;
    b = 8'h00;
    if (a >= NB) return 8'h00;
    for (int i = 0; i < 8; i++) b[7-i] = pix_of(line, 8*a + i);
    return b;
  endfunction

  // Each pixel: syncs and data settle, then p_tick high for two clocks.
  initial begin
    forever begin
      for (int v = 0; v < VT; v++) begin
        for (int h = 0; h < HT; h++) begin
          @(negedge clk_emu);
          gen_v     = v;
          gen_h     = h;
          hsync_ex  = !(h >= HA + HFP && h < HA + HFP + HS);
          vsync_ex  = !((v >= VA + VFP && v < VA + VFP + VS) || force_vs);
          pixel_ex  = pix_of(v, h);
          p_tick_ex = 1'b0;
          @(negedge clk_emu);
          @(negedge clk_emu);
          p_tick_ex = 1'b1;
          @(negedge clk_emu);
        end
      end
      gen_frame++;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_emu);
  endtask

  task automatic pulse_arm(input int ln);
    line_sel = 9'(ln);
    arm      = 1'b1;
    @(negedge clk_emu);
    arm      = 1'b0;
  endtask

  task automatic wait_gen(input int v, input int h, input string tag);
    int n;
    n = 0;
    while (!(gen_v == v && gen_h == h) && n < 2 * FRAME_CYC) begin
      @(negedge clk_emu);
      n++;
    end
    check({tag, "_reach"}, 32'(n < 2 * FRAME_CYC), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < DONE_BUDGET) begin
      @(negedge clk_emu);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_buffer(input int line, input string tag);
    for (int a = 0; a < (1 << AW); a++) begin
      rd_addr = AW'(a);
      @(negedge clk_emu);
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(exp_byte(line, a)));
    end
  endtask

  task automatic watch_quiet(input string tag);
    int act;
    act = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk_emu);
      if (busy !== 1'b0 || done !== 1'b0) act++;
    end
    check(tag, 32'(act), 32'd0);
  endtask

  task automatic fill_random();
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++)
        rand_px[v][h] = bit'($urandom_range(1, 0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int ln;
    int f0;

    // Reset state, then a full frame with no arm
    reset_n = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_err",  32'(err),     32'd0);
    check("rst_rd",   32'(rd_data), 32'd0);
    reset_n = 1'b1;
    begin
      int act;
      act = 0;
      repeat (FRAME_CYC) begin
        @(negedge clk_emu);
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) act++;
      end
      check("idle_frame", 32'(act), 32'd0);
    end

    // Line 0, first byte lit
    pat_mode = 0;
    pulse_arm(0);
    check("l0_busy", 32'(busy), 32'd1);
    check("l0_done_lo", 32'(done), 32'd0);
    wait_done("l0_done");
    check("l0_busy_end", 32'(busy), 32'd0);
    check("l0_err", 32'(err), 32'd0);
    check_buffer(0, "l0");

    // Last line, alternating pixels; busy must fall right after the last pixel
    pat_mode = 1;
    pulse_arm(VA - 1);
    check("last_done_clr", 32'(done), 32'd0);
    check("last_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < DONE_BUDGET) begin
      @(negedge clk_emu);
      n++;
    end
    check("last_busy_fall", 32'(n < DONE_BUDGET), 32'd1);
    check("last_drop_line", 32'(gen_v), 32'(VA - 1));
    check("last_drop_px", 32'(gen_h == HA - 1 || gen_h == HA), 32'd1);
    check("last_done", 32'(done), 32'd1);
    check_buffer(VA - 1, "last");

    // Random lines with random pixel content
    pat_mode = 2;
    for (int r = 0; r < 2; r++) begin
      fill_random();
      ln = int'($urandom_range(VA - 1, 0));
      pulse_arm(ln);
      wait_done($sformatf("rnd%0d_done", r));
      check_buffer(ln, $sformatf("rnd%0d", r));
    end

    // Illegal line index
    pulse_arm(VA);
    check("ill_err", 32'(err), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_done", 32'(done), 32'd0);
    watch_quiet("ill_quiet");
    check("ill_err_held", 32'(err), 32'd1);

    // Arm mid-frame for a line already passed: capture comes next frame
    wait_gen(5, 0, "mid");
    f0 = gen_frame;
    pulse_arm(2);
    check("mid_err_clr", 32'(err), 32'd0);
    wait_done("mid_done");
    check("mid_next_frame", 32'(gen_frame), 32'(f0 + 1));
    check_buffer(2, "mid");

    // vsync forced active in the middle of a capture
    pulse_arm(4);
    wait_gen(VT - 1, 0, "abort_eof");
    wait_gen(4, 10, "abort_mid");
    check("abort_busy_pre", 32'(busy), 32'd1);
    force_vs = 1'b1;
    tick(12);
    check("abort_err", 32'(err), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    force_vs = 1'b0;

    // Re-arm while busy: the second line is the one captured
    fill_random();
    wait_gen(VA, 0, "rearm_pre");
    pulse_arm(3);
    wait_gen(3, 20, "rearm_mid");
    check("rearm_busy1", 32'(busy), 32'd1);
    pulse_arm(7);
    check("rearm_busy2", 32'(busy), 32'd1);
    check("rearm_done_lo", 32'(done), 32'd0);
    wait_done("rearm_done");
    check_buffer(7, "rearm");

    // Reset pulse in the middle of a capture
    wait_gen(VA, 0, "rstcap_pre");
    pulse_arm(5);
    wait_gen(5, 16, "rstcap_mid");
    check("rstcap_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    rd_addr = '0;
    tick(2);
    check("rstcap_busy", 32'(busy),    32'd0);
    check("rstcap_done", 32'(done),    32'd0);
    check("rstcap_err",  32'(err),     32'd0);
    check("rstcap_rd",   32'(rd_data), 32'd0);
    reset_n = 1'b1;
    watch_quiet("rstcap_quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
